// File: rtl/piso_pkg.sv
// Shared definitions for the PISO serializer: FSM states, frame length and counter width.
// Optional parity bit per frame is enabled by defining PISO_PARITY_EN.
package piso_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

`ifdef PISO_PARITY_EN
    localparam int unsigned PARITY_BITS = 1;
`else
    localparam int unsigned PARITY_BITS = 0;
`endif

    function automatic int unsigned frame_len(input int unsigned width);
        return width + PARITY_BITS;
    endfunction

    // At least one bit so that a two-bit frame still has a usable counter.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Synchronous down-counter used to track the remaining bits of a frame.
// Load has priority over decrement; the count saturates at zero.
module piso_bit_counter #(
    parameter int unsigned CW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_value,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          zero
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter with valid/ready input and q/q_valid/last framing.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    input  logic             valid,
    output logic             ready,
    output logic             q,
    output logic             q_valid,
    output logic             last
);

    localparam int unsigned FRAME_LEN = frame_len(WIDTH);
    localparam int unsigned CW        = cnt_width(FRAME_LEN);
    localparam logic [CW-1:0] LOAD_VAL = CW'(FRAME_LEN - 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic             q_q;
    logic             q_d;
    logic             qv_q;
    logic             qv_d;
    logic             last_q;
    logic             last_d;

    logic [CW-1:0]    cnt;
    logic             cnt_zero;
    logic             accept;
    logic             advance;
    logic             first_bit;
    logic             head_bit;
    logic             next_bit;
    logic [WIDTH-1:0] data_rest;
    logic [WIDTH-1:0] shreg_next;

    assign accept  = valid && ready;
    assign advance = (state_q == ST_SHIFT) && !cnt_zero;

    // The first bit goes straight to the output flop on the accepting edge,
    // so the shift register only ever holds the bits still to come.
    assign first_bit  = (MSB_FIRST != 0) ? data[WIDTH-1]    : data[0];
    assign data_rest  = (MSB_FIRST != 0) ? (data << 1)      : (data >> 1);
    assign head_bit   = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];
    assign shreg_next = (MSB_FIRST != 0) ? (shreg_q << 1)   : (shreg_q >> 1);

`ifdef PISO_PARITY_EN
    logic par_q;
    logic par_d;

    always_comb begin
        par_d = accept ? ^data : par_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign next_bit = (cnt == CW'(1)) ? par_q : head_bit;
`else
    assign next_bit = head_bit;
`endif

    piso_bit_counter #(
        .CW (CW)
    ) u_bit_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .load_value (LOAD_VAL),
        .en         (advance),
        .count      (cnt),
        .zero       (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_SHIFT;
            ST_SHIFT: if (cnt_zero && !accept) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ready = !reset && ((state_q == ST_IDLE) || cnt_zero);
    end

    always_comb begin
        shreg_d = shreg_q;
        q_d     = 1'b0;
        qv_d    = 1'b0;
        last_d  = 1'b0;
        if (accept) begin
            shreg_d = data_rest;
            q_d     = first_bit;
            qv_d    = 1'b1;
        end else if (advance) begin
            shreg_d = shreg_next;
            q_d     = next_bit;
            qv_d    = 1'b1;
            last_d  = (cnt == CW'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q <= '0;
            q_q     <= 1'b0;
            qv_q    <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            q_q     <= q_d;
            qv_q    <= qv_d;
            last_q  <= last_d;
        end
    end

    assign q       = q_q;
    assign q_valid = qv_q;
    assign last    = last_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: an MSB-first and an LSB-first instance share stimulus
// and are compared every cycle against a queue-based frame model. Honours PISO_PARITY_EN.
module tb_piso_serializer;

    localparam int unsigned W = 8;
`ifdef PISO_PARITY_EN
    localparam int unsigned FL = W + 1;
    localparam logic [63:0] EXP_A5   = 64'h14A;
    localparam logic [63:0] EXP_01L  = 64'h101;
    localparam logic [63:0] EXP_FF00 = 64'h3FC00;
    localparam logic [63:0] EXP_LM2  = 64'h201;
    localparam logic [63:0] EXP_A53C = 64'h29478;
    localparam logic [63:0] EXP_07   = 64'h00F;
`else
    localparam int unsigned FL = W;
    localparam logic [63:0] EXP_A5   = 64'hA5;
    localparam logic [63:0] EXP_01L  = 64'h80;
    localparam logic [63:0] EXP_FF00 = 64'hFF00;
    localparam logic [63:0] EXP_LM2  = 64'h0101;
    localparam logic [63:0] EXP_A53C = 64'hA53C;
`endif

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic         valid = 1'b0;
    logic [W-1:0] data  = '0;

    logic rdy_m, q_m, qv_m, last_m;
    logic rdy_l, q_l, qv_l, last_l;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
        .clk(clk), .reset(reset), .data(data), .valid(valid),
        .ready(rdy_m), .q(q_m), .q_valid(qv_m), .last(last_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
        .clk(clk), .reset(reset), .data(data), .valid(valid),
        .ready(rdy_l), .q(q_l), .q_valid(qv_l), .last(last_l)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    task automatic checkv(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Frame as a bit vector, transmitted bit first at index FL-1.
    function automatic logic [63:0] frame_vec(input logic [W-1:0] w, input bit msb);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < W; i++) v[FL-1-i] = msb ? w[W-1-i] : w[i];
        if (FL > W) v[0] = ^w;
        return v;
    endfunction

    // Reference model: pending bits of the frame in flight plus the bit on the wire now.
    logic mq_m[$];
    logic mq_l[$];
    logic cur_v = 1'b0, cur_qm = 1'b0, cur_ql = 1'b0, cur_last = 1'b0;

    always @(posedge clk) begin
        logic [63:0] fm, fl;
        if (reset) begin
            mq_m.delete();
            mq_l.delete();
            cur_v = 1'b0; cur_qm = 1'b0; cur_ql = 1'b0; cur_last = 1'b0;
        end else begin
            if (valid && (mq_m.size() == 0)) begin
                fm = frame_vec(data, 1'b1);
                fl = frame_vec(data, 1'b0);
                for (int i = FL - 1; i >= 0; i--) begin
                    mq_m.push_back(fm[i]);
                    mq_l.push_back(fl[i]);
                end
            end
            if (mq_m.size() > 0) begin
                cur_qm   = mq_m.pop_front();
                cur_ql   = mq_l.pop_front();
                cur_v    = 1'b1;
                cur_last = (mq_m.size() == 0);
            end else begin
                cur_v = 1'b0; cur_qm = 1'b0; cur_ql = 1'b0; cur_last = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic er;
        if (chk_on) begin
            er = !reset && (mq_m.size() == 0);
            check1("ready_m", rdy_m, er);
            check1("ready_l", rdy_l, er);
            check1("qv_m", qv_m, cur_v);
            check1("qv_l", qv_l, cur_v);
            check1("last_m", last_m, cur_last);
            check1("last_l", last_l, cur_last);
            check1("q_m", q_m, cur_qm);
            check1("q_l", q_l, cur_ql);
        end
    end

    logic [63:0] cap_m = '0, cap_l = '0, lmask = '0;
    int cap_n = 0;

    always @(negedge clk) begin
        if (qv_m === 1'b1) begin
            cap_m = {cap_m[62:0], q_m};
            lmask = {lmask[62:0], last_m};
            cap_n++;
        end
        if (qv_l === 1'b1) cap_l = {cap_l[62:0], q_l};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cap();
        cap_m = '0; cap_l = '0; lmask = '0; cap_n = 0;
    endtask

    // Presents w with valid high until it is accepted; leaves valid asserted.
    task automatic push_word(input logic [W-1:0] w);
        int  n;
        bit  done;
        n = 0; done = 1'b0;
        valid = 1'b1;
        data  = w;
        while (!done && n < 60) begin
            @(negedge clk);
            if (rdy_m) done = 1'b1;
            step();
            n++;
        end
        if (!done) check1("accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_idle();
        int n;
        bit done;
        n = 0; done = 1'b0;
        while (!done && n < 80) begin
            @(negedge clk);
            if (rdy_m && !qv_m) done = 1'b1;
            n++;
        end
        if (!done) check1("idle_timeout", 1'b0, 1'b1);
        step();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checkv("model_a5", frame_vec(8'hA5, 1'b1), EXP_A5);
        checkv("model_01_lsb", frame_vec(8'h01, 1'b0), EXP_01L);

        reset = 1'b1;
        step();
        step();
        chk_on = 1'b1;
        @(negedge clk);
        check1("rst_q", q_m, 1'b0);
        check1("rst_qv", qv_m, 1'b0);
        check1("rst_ready", rdy_m, 1'b0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check1("post_rst_ready", rdy_m, 1'b1);
        step();

        clear_cap();
        push_word(8'hA5);
        valid = 1'b0;
        wait_idle();
        checkv("a5_bits", cap_m, EXP_A5);
        checkv("a5_last", lmask, 64'h1);
        checkv("a5_len", 64'(cap_n), 64'(FL));

        clear_cap();
        push_word(8'h01);
        valid = 1'b0;
        wait_idle();
        checkv("lsb_01_bits", cap_l, EXP_01L);

        clear_cap();
        push_word(8'hFF);
        push_word(8'h00);
        valid = 1'b0;
        wait_idle();
        checkv("b2b_bits", cap_m, EXP_FF00);
        checkv("b2b_last", lmask, EXP_LM2);
        checkv("b2b_len", 64'(cap_n), 64'(2 * FL));

        clear_cap();
        push_word(8'hA5);
        valid = 1'b0;
        data  = 8'h11;
        step();
        step();
        data  = 8'h3C;
        valid = 1'b1;
        push_word(8'h3C);
        valid = 1'b0;
        wait_idle();
        checkv("ignored_bits", cap_m, EXP_A53C);

`ifdef PISO_PARITY_EN
        clear_cap();
        push_word(8'h07);
        valid = 1'b0;
        wait_idle();
        checkv("parity_07_bits", cap_m, EXP_07);
        checkv("parity_07_last", lmask, 64'h1);
`endif

        push_word(8'hA5);
        valid = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        @(negedge clk);
        check1("midrst_q", q_m, 1'b0);
        check1("midrst_qv", qv_m, 1'b0);
        check1("midrst_ready", rdy_m, 1'b0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check1("midrst_release_ready", rdy_m, 1'b1);
        step();
        clear_cap();
        repeat (12) step();
        checkv("midrst_no_resume", 64'(cap_n), 64'h0);

        repeat (500) begin
            reset = ($urandom_range(0, 79) == 0);
            valid = ($urandom_range(0, 3) != 0);
            data  = W'($urandom);
            step();
        end
        reset = 1'b0;
        valid = 1'b0;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
